encoder_42_sync: RTL and testbench

Synchronous 4-to-2 event encoder: the input-side counterpart of the 2-to-4 decoder used on the board I/O path. It takes four raw, asynchronous input lines (push buttons or switches). Each line is synchronized and debounced. When any line makes a debounced 0→1 transition, the block outputs the line's 2-bit index with a one-cycle valid pulse. The encoded code can drive the 2-to-4 decoder directly, closing the loop from buttons to one-hot LEDs.

---
 rtl/encoder_42_sync.sv | 98 +++++++++
 tb/tb_encoder_42_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_42_sync.sv
// Synchronous 4-to-2 event encoder: four raw lines are synchronized and debounced,
// and each debounced rising edge is reported as a 2-bit index with a one-cycle valid pulse.
module encoder_42_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] d,
    output logic [1:0] y,
    output logic       valid,
    output logic       multi,
    output logic       any
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s1_q, s2_q;
    logic [3:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       flip, rise;
    logic [1:0]       y_q, y_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic             any_q;

    // Highest set bit wins; callers guarantee v != 0.
    function automatic logic [1:0] prio_idx(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic more_than_one(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    always_comb begin
        stable_d = stable_q;
        flip     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                flip[i]     = 1'b1;
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        rise = flip & s2_q;
    end

    // Events are only taken with en high; otherwise y and multi hold.
    always_comb begin
        y_d     = y_q;
        multi_d = multi_q;
        valid_d = 1'b0;
        if (en && (rise != 4'b0000)) begin
            y_d     = prio_idx(rise);
            multi_d = more_than_one(rise);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 4'b0000;
            s2_q     <= 4'b0000;
            stable_q <= 4'b0000;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            y_q      <= 2'b00;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
            any_q    <= 1'b0;
        end else begin
            s1_q     <= d;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            y_q      <= y_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            any_q    <= |stable_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign multi = multi_q;
    assign any   = any_q;

endmodule

// File: tb/tb_encoder_42_sync.sv
// Bench for encoder_42_sync: directed scenarios plus random line activity,
// checked every cycle against a run-length behavioural model.
module tb_encoder_42_sync;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] d   = 4'b0000;
    logic [1:0] y;
    logic       valid, multi, any;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;

    // model state
    logic [3:0] m_s1 = '0, m_s2 = '0, m_stab = '0;
    int         run [4] = '{0, 0, 0, 0};
    logic [1:0] ym = '0;
    logic       vm = 1'b0, mm = 1'b0, am = 1'b0;

    encoder_42_sync #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .y(y), .valid(valid), .multi(multi), .any(any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Debounced state flips once the delayed line has disagreed for N edges in a row.
    task automatic model_step();
        logic [3:0] rise, nxt;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
            ym = '0; vm = 1'b0; mm = 1'b0; am = 1'b0;
        end else begin
            rise = '0;
            nxt  = m_stab;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_stab[i]) begin
                    run[i]++;
                    if (run[i] == N) begin
                        nxt[i] = m_s2[i];
                        run[i] = 0;
                        if (m_s2[i]) rise[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            vm = 1'b0;
            if (rise != 0 && en) begin
                vm = 1'b1;
                mm = ($countones(rise) > 1);
                for (int i = 0; i < 4; i++) if (rise[i]) ym = 2'(i);
            end
            m_stab = nxt;
            am     = |nxt;
            m_s2   = m_s1;
            m_s1   = d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        chk("valid", valid, vm);
        chk("y", y, ym);
        chk("multi", multi, mm);
        chk("any", any, am);
        if (valid) nvalid++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edges until valid is seen; bounded, returns -1 on timeout.
    task automatic lat(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (valid) begin
                n = i;
                break;
            end
        end
    endtask

    int n, v0;

    initial begin
        // reset with all lines held high
        rst = 1'b1; d = 4'b1111;
        ticks(2);
        chk("rst_valid", valid, 0);
        chk("rst_y", y, 0);
        chk("rst_any", any, 0);
        chk("rst_multi", multi, 0);
        rst = 1'b0;
        lat(n);
        chk("rst_rel_lat", n, 6);
        chk("rst_rel_y", y, 3);
        chk("rst_rel_multi", multi, 1);
        chk("rst_rel_any", any, 1);
        tick();
        chk("rst_rel_pulse", valid, 0);
        d = 4'b0000; ticks(10);

        // single press and release
        d = 4'b0100;
        lat(n);
        chk("press_lat", n, 6);
        chk("press_y", y, 2);
        chk("press_multi", multi, 0);
        v0 = nvalid; d = 4'b0000; ticks(10);
        chk("release_nvalid", nvalid - v0, 0);
        chk("release_y", y, 2);
        chk("release_any", any, 0);

        // glitch rejection, then minimum-length pulse
        v0 = nvalid; d = 4'b0001; ticks(3); d = 4'b0000; ticks(10);
        chk("glitch_nvalid", nvalid - v0, 0);
        v0 = nvalid; d = 4'b0001; ticks(4); d = 4'b0000; ticks(10);
        chk("pulse4_nvalid", nvalid - v0, 1);
        chk("pulse4_y", y, 0);

        // priority and multi
        d = 4'b1010;
        lat(n);
        chk("prio_y", y, 3);
        chk("prio_multi", multi, 1);
        v0 = nvalid; ticks(10);
        chk("prio_single", nvalid - v0, 0);
        d = 4'b0000; ticks(10);
        d = 4'b0010;
        lat(n);
        chk("bit1_y", y, 1);
        chk("bit1_multi", multi, 0);
        d = 4'b0000; ticks(10);

        // enable gating: lost event is not replayed
        en = 1'b0; d = 4'b0100; v0 = nvalid; ticks(10);
        chk("en0_nvalid", nvalid - v0, 0);
        chk("en0_any", any, 1);
        chk("en0_y", y, 1);
        en = 1'b1; ticks(10);
        chk("en1_late", nvalid - v0, 0);
        d = 4'b0000; ticks(10);
        d = 4'b0010;
        lat(n);
        chk("en_repress_y", y, 1);
        d = 4'b0000; ticks(10);

        // reset mid-debounce
        d = 4'b1000; ticks(3);
        rst = 1'b1; tick(); rst = 1'b0;
        lat(n);
        chk("midrst_lat", n, 6);
        chk("midrst_y", y, 3);
        d = 4'b0000; ticks(10);

        // back-to-back events on consecutive cycles
        d = 4'b0001; tick(); d = 4'b0011;
        lat(n);
        chk("b2b_y0", y, 0);
        tick();
        chk("b2b_valid1", valid, 1);
        chk("b2b_y1", y, 1);
        d = 4'b0000; ticks(10);

        // reset on the event edge wins
        d = 4'b0100; ticks(5);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_win_valid", valid, 0);
        d = 4'b0000; ticks(10);

        // random activity
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 30) == 0) en = ~en;
            rst = ($urandom_range(0, 400) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
